// File: rtl/square_wave_meter.sv
// square_wave_meter: measures the period and high time of an asynchronous
// square wave in clk cycles. Each completed period is reported through a
// valid/ack handshake. The block also flags lock against EXP_PERIOD +/- TOL
// and raises timeout when rising edges stop arriving.
// Optional feature: define SQUARE_WAVE_METER_DUTY_CHECK_EN to add the duty_ok
// output, which indicates a near-50% duty cycle.
module square_wave_meter #(
    parameter int CNT_W       = 25,
    parameter int EXP_PERIOD  = 25_000_000,
    parameter int TOL         = 250,
    parameter int TIMEOUT_CYC = 30_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             overrun,
    output logic             lock,
    output logic             timeout
`ifdef SQUARE_WAVE_METER_DUTY_CHECK_EN
    ,
    output logic             duty_ok
`endif
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEAS_HIGH,
        S_MEAS_LOW
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_hi_lat;

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_run_inc;
    logic             w_capture;
    logic             w_hi_load;
    logic             w_restart;
    logic             w_to_hit;
    logic             w_ack_acc;

    logic signed [CNT_W:0] w_per_diff;
    logic        [CNT_W:0] w_per_abs;
    logic                  w_lock;

    // Two-flop synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 & ~r_prev;
    assign w_fall    = ~r_sync2 & r_prev;
    assign w_run_inc = r_run_cnt + 1'b1;
    assign w_ack_acc = meas_ack & meas_valid;

    // Lock test on the period being captured, using a signed difference one bit wider
    assign w_per_diff = $signed({1'b0, w_run_inc}) - $signed((CNT_W + 1)'(EXP_PERIOD));
    assign w_per_abs  = w_per_diff[CNT_W] ? $unsigned(-w_per_diff) : $unsigned(w_per_diff);
    assign w_lock     = (w_per_abs <= (CNT_W + 1)'(TOL));

`ifdef SQUARE_WAVE_METER_DUTY_CHECK_EN
    logic signed [CNT_W+1:0] w_duty_diff;
    logic        [CNT_W+1:0] w_duty_abs;
    logic                    w_duty_ok;

    assign w_duty_diff = $signed({1'b0, r_hi_lat, 1'b0}) - $signed({2'b00, w_run_inc});
    assign w_duty_abs  = w_duty_diff[CNT_W+1] ? $unsigned(-w_duty_diff) : $unsigned(w_duty_diff);
    assign w_duty_ok   = (w_duty_abs <= (CNT_W + 2)'(2 * TOL));
`endif

    // Cycle counter since the last rise. It saturates so that the +1 terms never wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if (w_rise) begin
            r_run_cnt <= '0;
        end else if (r_run_cnt != RUN_MAX) begin
            r_run_cnt <= w_run_inc;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Timeout overrides every state
    always_comb begin
        w_state_nxt = r_state;
        if (w_to_hit) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:      if (w_rise) w_state_nxt = S_MEAS_HIGH;
                S_MEAS_HIGH: if (w_fall) w_state_nxt = S_MEAS_LOW;
                S_MEAS_LOW:  if (w_rise) w_state_nxt = S_MEAS_HIGH;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM output strobes that drive the result datapath
    always_comb begin
        w_to_hit  = ~w_rise & (r_run_cnt == RUN_MAX);
        w_capture = (r_state == S_MEAS_LOW)  & w_rise;
        w_restart = (r_state == S_IDLE)      & w_rise;
        w_hi_load = (r_state == S_MEAS_HIGH) & w_fall;
    end

    // High-time latch, loaded when the high phase ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi_lat <= '0;
        end else if (w_hi_load) begin
            r_hi_lat <= w_run_inc;
        end
    end

    // Result registers, handshake and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
            lock       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (w_capture) begin
                period_cnt <= w_run_inc;
                high_cnt   <= r_hi_lat;
                meas_valid <= 1'b1;
                lock       <= w_lock;
            end else if (w_ack_acc) begin
                meas_valid <= 1'b0;
            end

            // An ack in the capture cycle consumes the old result, so it is not an overwrite
            if (w_capture && meas_valid && !meas_ack) begin
                overrun <= 1'b1;
            end else if (w_ack_acc) begin
                overrun <= 1'b0;
            end

            if (w_to_hit) begin
                timeout <= 1'b1;
                lock    <= 1'b0;
            end else if (w_capture || w_restart) begin
                timeout <= 1'b0;
            end
        end
    end

`ifdef SQUARE_WAVE_METER_DUTY_CHECK_EN
    // Duty-cycle flag, refreshed at each capture and cleared on timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_ok <= 1'b0;
        end else if (w_to_hit) begin
            duty_ok <= 1'b0;
        end else if (w_capture) begin
            duty_ok <= w_duty_ok;
        end
    end
`endif

endmodule

// File: tb/tb_square_wave_meter.sv
// Testbench for square_wave_meter with small parameters. Stimulus pushes the
// expected result of each completed period into a queue, and a monitor pops
// and compares on every accepted result.
module tb_square_wave_meter;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       sig_in   = 1'b0;
    logic       meas_ack = 1'b1;
    logic [7:0] period_cnt;
    logic [7:0] high_cnt;
    logic       meas_valid;
    logic       overrun;
    logic       lock;
    logic       timeout;
`ifdef SQUARE_WAVE_METER_DUTY_CHECK_EN
    logic       duty_ok;
`endif

    square_wave_meter #(
        .CNT_W      (8),
        .EXP_PERIOD (20),
        .TOL        (1),
        .TIMEOUT_CYC(200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .meas_ack  (meas_ack),
        .period_cnt(period_cnt),
        .high_cnt  (high_cnt),
        .meas_valid(meas_valid),
        .overrun   (overrun),
        .lock      (lock),
        .timeout   (timeout)
`ifdef SQUARE_WAVE_METER_DUTY_CHECK_EN
        ,
        .duty_ok   (duty_ok)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int hi;
        bit lk;
        bit dty;
    } exp_t;

    exp_t q[$];
    int   errors  = 0;
    int   checks  = 0;
    bit   push_en = 1'b1;
    bit   m_armed = 1'b0;
    int   m_len   = 0;
    int   m_hi    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_push(input int len, input int hi);
        exp_t e;
        int   d;
        e.per = len;
        e.hi  = hi;
        e.lk  = (len >= 19) && (len <= 21);
        d     = 2 * hi - len;
        if (d < 0) d = -d;
        e.dty = (d <= 2);
        q.push_back(e);
    endtask

    // One clock: inputs change 2 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
        m_len++;
        if (sig_in) m_hi++;
    endtask

    // A driven rise closes the period in progress, whose expectation is queued then
    task automatic set_sig(input logic v);
        if (v && !sig_in) begin
            if (m_armed && push_en) sb_push(m_len, m_hi);
            m_armed = 1'b1;
            m_len   = 0;
            m_hi    = 0;
        end
        sig_in = v;
    endtask

    task automatic period(input int h, input int l);
        set_sig(1'b1);
        repeat (h) tick();
        set_sig(1'b0);
        repeat (l) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},  period_cnt, 0);
        check({tag, "_high"},    high_cnt,   0);
        check({tag, "_valid"},   meas_valid, 0);
        check({tag, "_overrun"}, overrun,    0);
        check({tag, "_lock"},    lock,       0);
        check({tag, "_timeout"}, timeout,    0);
`ifdef SQUARE_WAVE_METER_DUTY_CHECK_EN
        check({tag, "_duty"},    duty_ok,    0);
`endif
    endtask

    // Monitor: every accepted result must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && meas_valid && meas_ack) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got period=%0d high=%0d, expected no result", period_cnt, high_cnt);
            end else begin
                e = q.pop_front();
                check("sb_period",  period_cnt, e.per);
                check("sb_high",    high_cnt,   e.hi);
                check("sb_lock",    lock,       int'(e.lk));
                check("sb_timeout", timeout,    0);
`ifdef SQUARE_WAVE_METER_DUTY_CHECK_EN
                check("sb_duty",    duty_ok,    int'(e.dty));
`endif
            end
        end
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // T1: 10/10 cycles, locked
        repeat (3) period(10, 10);

        // T2: 7/15 cycles, off-lock and off-duty
        repeat (2) period(7, 15);

        // T3: withheld ack, then overrun, then a single ack pulse
        push_en  = 1'b0;
        meas_ack = 1'b0;
        repeat (3) period(10, 10);
        tick();
        check("t3_valid_held", meas_valid, 1);
        check("t3_overrun",    overrun,    1);
        sb_push(20, 10);
        push_en  = 1'b1;
        meas_ack = 1'b1;
        tick();
        check("t3_valid_clr",   meas_valid, 0);
        check("t3_overrun_clr", overrun,    0);

        // T4: locked wave, then hold low until timeout, then resume
        repeat (3) period(10, 10);
        while (m_len < 202) tick();
        check("t4_timeout_early", timeout, 0);
        check("t4_lock_early",    lock,    1);
        tick();
        check("t4_timeout",      timeout,    1);
        check("t4_lock_drop",    lock,       0);
        check("t4_period_kept",  period_cnt, 20);
        check("t4_high_kept",    high_cnt,   10);
        check("t4_valid",        meas_valid, 0);
        m_armed = 1'b0;
        set_sig(1'b1);
        repeat (2) tick();
        check("t4_timeout_hold", timeout, 1);
        tick();
        check("t4_timeout_clr",  timeout, 0);
        repeat (7) tick();
        set_sig(1'b0);
        repeat (10) tick();
        period(10, 10);

        // T5: reset pulse in the middle of the low phase
        set_sig(1'b1);
        repeat (10) tick();
        set_sig(1'b0);
        repeat (5) tick();
        check("t5_lock_pre", lock, 1);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        m_armed = 1'b0;
        check_all_zero("t5_reset");
        repeat (5) tick();
        repeat (2) period(10, 10);
        set_sig(1'b1);
        repeat (6) tick();

        check("sb_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
